// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS MULT/MULTU/DIV/DIVU (33 cycles) and MTHI/MTLO; holds HI/LO (ports: clk, rst, start, mdFunct, opA, opB -> busy, done, hi, lo)
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  mdFunct,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam logic [5:0] FUN_MTHI  = 6'b010001;
  localparam logic [5:0] FUN_MTLO  = 6'b010011;
  localparam logic [5:0] FUN_MULT  = 6'b011000;
  localparam logic [5:0] FUN_MULTU = 6'b011001;
  localparam logic [5:0] FUN_DIV   = 6'b011010;
  localparam logic [5:0] FUN_DIVU  = 6'b011011;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t      state;
  logic [5:0]  cnt;
  logic        is_div, neg_res, neg_rem;
  logic [31:0] m;
  logic [63:0] p;
  logic        sgn, div_op, md_op;
  logic [31:0] a_mag, b_mag, diff;
  logic [32:0] add, r;
  logic        ge;
  logic [63:0] mul_next, div_next, prod_neg;
  assign sgn    = mdFunct == FUN_MULT || mdFunct == FUN_DIV;
  assign div_op = mdFunct == FUN_DIV || mdFunct == FUN_DIVU;
  assign md_op  = sgn || mdFunct == FUN_MULTU || mdFunct == FUN_DIVU;
  assign a_mag  = sgn && opA[31] ? -opA : opA;
  assign b_mag  = sgn && opB[31] ? -opB : opB;
  // multiply: p = {accumulator, remaining multiplier bits}, shifted right each step
  assign add      = {1'b0, p[63:32]} + {1'b0, m};
  assign mul_next = p[0] ? {add, p[31:1]} : {1'b0, p[63:32], p[31:1]};
  // divide: p = {partial remainder, dividend bits / quotient bits}, shifted left each step
  assign r        = {p[63:32], p[31]};
  assign ge       = r >= {1'b0, m};
  assign diff     = r[31:0] - m;
  assign div_next = {ge ? diff : r[31:0], p[30:0], ge};
  assign prod_neg = -p;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      m       <= '0;
      p       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (mdFunct == FUN_MTHI) hi <= opA;
          else if (mdFunct == FUN_MTLO) lo <= opA;
          else if (md_op) begin
            is_div  <= div_op;
            neg_res <= sgn && (opA[31] ^ opB[31]);
            neg_rem <= sgn && opA[31];
            m       <= div_op ? b_mag : a_mag;
            p       <= {32'b0, div_op ? a_mag : b_mag};
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else $warning("mul_div_unit: unrecognised funct %b ignored", mdFunct);
        end
        RUN: begin
          p     <= is_div ? div_next : mul_next;
          cnt   <= cnt + 6'd1;
          state <= cnt == 6'd31 ? FIX : RUN;
        end
        FIX: begin
          if (is_div) begin
            lo <= neg_res ? -p[31:0] : p[31:0];
            hi <= neg_rem ? -p[63:32] : p[63:32];
          end else begin
            lo <= neg_res ? prod_neg[31:0] : p[31:0];
            hi <= neg_res ? prod_neg[63:32] : p[63:32];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit with directed vectors
module tb_mul_div_unit;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MTLO  = 6'b010011;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  mdFunct = 6'b0;
  logic [31:0] opA = '0, opB = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  mul_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .mdFunct(mdFunct), .opA(opA), .opB(opB),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done) begin
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_done got hi=%h lo=%h, required no done", hi, lo);
    end else begin
      exp_t e;
      e = q.pop_front();
      if (hi !== e.hi || lo !== e.lo) begin
        fails++;
        $display("FAIL result got hi=%h lo=%h, required hi=%h lo=%h", hi, lo, e.hi, e.lo);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h, required %h", name, act, exp);
    end
  endtask
  task automatic push(input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    q.push_back(e);
  endtask
  // called right after the accept edge; returns at the negedge where done is seen
  task automatic wait_done(input string name);
    int n = 0;
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (busy) n++;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_busy_cycles"}, n, 33);
  endtask
  task automatic op(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] eh, input logic [31:0] el);
    mdFunct = f;
    opA = a;
    opB = b;
    start = 1'b1;
    push(eh, el);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(name);
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    @(posedge clk);
    #1 start = 1'b1; mdFunct = MTHI; opA = 32'h12345678;
    @(posedge clk);
    #1 chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", 32'(busy), 0);
    mdFunct = MTLO; opA = 32'h9ABCDEF0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("mtlo_hi", hi, 32'h12345678);
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    op("mult", MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    op("multu", MULTU, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB);
    op("mult_big", MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    op("div", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    op("divu", DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    op("div_mixed", DIV, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2);
    op("divu_zero", DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    op("div_zero_neg", DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'd1);
    op("div_zero_pos", DIV, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF);
    op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    // a start pulse mid-run must be ignored
    mdFunct = MULT; opA = 32'd100; opB = 32'd200; start = 1'b1;
    push(32'd0, 32'd20000);
    @(posedge clk);
    #1 start = 1'b0;
    fork
      begin
        repeat (9) @(posedge clk);
        #1 mdFunct = DIV; opA = 32'd7; opB = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join_none
    wait_done("ignore");
    @(posedge clk);
    #1;
    // reset mid-run aborts with no write
    mdFunct = MULT; opA = 32'd11; opB = 32'd13; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    repeat (20) @(negedge clk);
    chk("abort_hi_later", hi, 0);
    chk("abort_lo_later", lo, 0);
    @(posedge clk);
    #1;
    // start held high: re-accepted at the done cycle's edge
    mdFunct = MULT; opA = 32'd3; opB = 32'd5; start = 1'b1;
    push(32'd0, 32'd15);
    @(posedge clk);
    #1;
    wait_done("b2b_first");
    opA = 32'hFFFFFFFE; opB = 32'd6;
    push(32'hFFFFFFFF, 32'hFFFFFFF4);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_accept_busy", 32'(busy), 1);
    begin
      int n = 1;
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (done) seen = 1;
        else if (busy) n++;
      end
      chk("b2b_second_done_seen", 32'(seen), 1);
      chk("b2b_second_busy_cycles", n, 33);
    end
    @(posedge clk);
    #1 mdFunct = 6'b100000; opA = 32'hDEADBEEF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("bad_funct_busy", 32'(busy), 0);
    chk("bad_funct_hi", hi, 32'hFFFFFFFF);
    chk("bad_funct_lo", lo, 32'hFFFFFFF4);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
